// File: rtl/ucsbece154a_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ucsbece154a_mem_pkg
//  Description : Shared types and helpers for the unified memory responder:
//                FSM state encoding, word size and a constant-time log2.
//  Revision    : 1.0 - initial release
// ============================================================================
package ucsbece154a_mem_pkg;

    // Responder FSM states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        MEMST_IDLE   = 2'd0,
        MEMST_WAIT   = 2'd1,
        MEMST_ACCESS = 2'd2,
        MEMST_RESP   = 2'd3
    } memst_e;

    localparam int unsigned WORD_BYTES = 4;

    // Ceiling log2, used to size the word index from the array depth
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ucsbece154a_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : ucsbece154a_mem_array
//  Description : Single-port 32-bit word RAM, synchronous write and
//                synchronous (read-first) read; maps onto block RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module ucsbece154a_mem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // One access per enabled cycle; the output register holds between accesses
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ucsbece154a_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ucsbece154a_mem_responder
//  Description : Valid/ready memory responder for the multicycle core with a
//                configurable number of wait states before each array access.
//  Revision    : 1.0 - initial release
// ============================================================================
module ucsbece154a_mem_responder
    import ucsbece154a_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned c_aw         = clog2(DEPTH_WORDS);
    localparam logic [32:0] c_span_bytes = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);
    localparam logic [3:0]  c_wait_load  = 4'(WAIT_CYCLES);
    localparam bit          c_has_wait   = (WAIT_CYCLES != 0);

    memst_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rd_sel_q, rd_sel_d;

    logic [32:0]     w_diff;
    logic            w_err;
    logic            w_ram_en;
    logic [31:0]     w_ram_rdata;

    // Decode the latched address; bit 32 of the difference flags addr < BASE_ADDR
    always_comb begin
        w_diff   = {1'b0, addr_q} - {1'b0, BASE_ADDR};
        w_err    = (|addr_q[1:0]) | w_diff[32] | ({1'b0, w_diff[31:0]} >= c_span_bytes);
        w_ram_en = (state_q == MEMST_ACCESS) & ~w_err & ~reset;
    end

    ucsbece154a_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (c_aw)
    ) u_array (
        .clk   (clk),
        .en    (w_ram_en),
        .we    (we_q),
        .addr  (w_diff[c_aw+1:2]),
        .wdata (wdata_q),
        .rdata (w_ram_rdata)
    );

    // Next-state, counter and response-register logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rd_sel_d    = rd_sel_q;
        case (state_q)
            MEMST_IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    cnt_d   = c_wait_load;
                    state_d = c_has_wait ? MEMST_WAIT : MEMST_ACCESS;
                end
            end
            MEMST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = MEMST_ACCESS;
                end
            end
            MEMST_ACCESS: begin
                // Read data arrives from the RAM output register in RESP; only
                // successful loads let it through to rsp_rdata_o
                rsp_err_d   = w_err;
                rd_sel_d    = ~we_q & ~w_err;
                rsp_valid_d = 1'b1;
                state_d     = MEMST_RESP;
            end
            default: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = MEMST_IDLE;
                end
            end
        endcase
    end

    // Control state with synchronous reset; drops any in-flight request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= MEMST_IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rd_sel_q    <= rd_sel_d;
        end
    end

    // Request latches need no reset; they are only consumed after a new accept
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign req_ready_o = (state_q == MEMST_IDLE) & ~reset;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rd_sel_q ? w_ram_rdata : 32'd0;

endmodule
`default_nettype wire
